// File: rtl/multi_edge_counter.sv
// Multi-channel edge counter. Each channel synchronises an asynchronous input and
// detects edges in the selected mode. Qualified edges count from 1 up to a per-channel rollover value.
module multi_edge_counter #(
  parameter int NUM_CH       = 4,
  parameter int NUM_CNT_BITS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           clear,
  input  logic [1:0]                     edge_mode,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              in_sig,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              rollover_pulse,
  output logic                           any_rollover
);

  localparam int W = NUM_CNT_BITS;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } mode_e;

  mode_e w_mode;
  assign w_mode = mode_e'(edge_mode);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_prev;
      logic [W-1:0]           r_count;
      logic                   r_pulse;
      logic                   w_last;
      logic                   w_rise;
      logic                   w_fall;
      logic                   w_edge;
      logic [W-1:0]           w_rv;

      assign w_rv   = rollover_val[gi*W +: W];
      assign w_last = r_sync[SYNC_STAGES-1];
      assign w_rise = w_last & ~r_prev;
      assign w_fall = ~w_last & r_prev;

      // Mode is applied combinationally on the history registers, so a mode
      // change alone can never manufacture an edge.
      always_comb begin
        w_edge = 1'b0;
        case (w_mode)
          MODE_RISE: w_edge = w_rise;
          MODE_FALL: w_edge = w_fall;
          MODE_BOTH: w_edge = w_rise | w_fall;
          default:   w_edge = 1'b0;
        endcase
      end

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          r_sync <= '0;
          r_prev <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], in_sig[gi]};
          r_prev <= w_last;
        end
      end

      // ">=" rather than "==" so a rollover value lowered below the count wraps on the next edge.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          r_count <= '0;
          r_pulse <= 1'b0;
        end else if (clear || (w_rv == '0)) begin
          r_count <= '0;
          r_pulse <= 1'b0;
        end else if (count_enable[gi] && w_edge) begin
          if (r_count >= w_rv) begin
            r_count <= {{(W-1){1'b0}}, 1'b1};
            r_pulse <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
            r_pulse <= 1'b0;
          end
        end else begin
          r_pulse <= 1'b0;
        end
      end

      assign count_out[gi*W +: W] = r_count;
      assign rollover_flag[gi]    = (r_count == w_rv) && (w_rv != '0);
      assign rollover_pulse[gi]   = r_pulse;
    end
  endgenerate

  assign any_rollover = |rollover_pulse;

endmodule
